// File: rtl/cost_accumulator.sv
// -----------------------------------------------------------------------------
// cost_accumulator
//   Hardware cost computation for the training loop. Each newOutput strobe
//   captures one perceptron output vector plus its per-channel target bits.
//   Channels are processed serially, one per cycle. Each channel goes through a
//   hard-sigmoid approximation, then a squared or absolute error against the
//   target. The errors are summed over SEQ_LEN samples, and the saturated sum
//   is presented on costFunc with a one-cycle newCostFunc strobe. A saturating
//   counter tracks the elements whose sign-based prediction missed the target.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   clearAcc       synchronous clear of all accumulation state (costFunc kept)
//   newOutput      one-cycle strobe: networkOutput/target valid
//   networkOutput  OUTPUT_SZ signed Q(QN.QM) words, channel c at [c*BITWIDTH +: BITWIDTH]
//   target         expected bit per channel
//   busy           high while a captured sample is being processed
//   costFunc       saturated sequence cost, unsigned Q(QN.QM)
//   newCostFunc    one-cycle pulse when costFunc is updated
//   wrongBits      cumulative mispredicted elements, saturating
//   overrun        sticky flag: newOutput arrived while busy
// -----------------------------------------------------------------------------
module cost_accumulator #(
    parameter int OUTPUT_SZ = 1,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int BITWIDTH  = QN + QM + 1,
    parameter int SEQ_LEN   = 8,
    parameter int MODE      = 0,
    parameter int CNT_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clearAcc,
    input  logic                          newOutput,
    input  logic [OUTPUT_SZ*BITWIDTH-1:0] networkOutput,
    input  logic [OUTPUT_SZ-1:0]          target,
    output logic                          busy,
    output logic [BITWIDTH-1:0]           costFunc,
    output logic                          newCostFunc,
    output logic [CNT_W-1:0]              wrongBits,
    output logic                          overrun
);

    // The accumulator can never wrap: one term is at most 2^QM < 2^(BITWIDTH-1).
    localparam int ACC_W = BITWIDTH + $clog2(SEQ_LEN * OUTPUT_SZ) + 1;
    localparam int CH_W  = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
    localparam int SC_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int SW    = BITWIDTH + 1;

    localparam logic [CH_W-1:0]       LAST_CH     = CH_W'(OUTPUT_SZ - 1);
    localparam logic [SC_W-1:0]       LAST_SAMPLE = SC_W'(SEQ_LEN - 1);
    localparam logic signed [SW-1:0]  HALF_S      = SW'(2 ** (QM - 1));
    localparam logic signed [SW-1:0]  ONE_S       = SW'(2 ** QM);
    localparam logic signed [SW-1:0]  ZERO_S      = SW'(0);
    localparam logic [QM:0]           ONE_E       = {1'b1, {QM{1'b0}}};
    localparam logic [ACC_W-1:0]      COST_MAX    = {{(ACC_W - BITWIDTH + 1){1'b0}}, {(BITWIDTH - 1){1'b1}}};
    localparam logic [CNT_W-1:0]      CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_r;
    state_t                        nextState_s;
    logic [OUTPUT_SZ*BITWIDTH-1:0] capWord_r;
    logic [OUTPUT_SZ-1:0]          capTarget_r;
    logic [CH_W-1:0]               ch_r;
    logic [SC_W-1:0]               sampleCnt_r;
    logic [ACC_W-1:0]              acc_r;
    logic                          busy_r;
    logic                          busyNext_s;
    logic [BITWIDTH-1:0]           costFunc_r;
    logic                          newCostFunc_r;
    logic [CNT_W-1:0]              wrongBits_r;
    logic                          overrun_r;

    logic signed [BITWIDTH-1:0]    x_s;
    logic signed [SW-1:0]          xExt_s;
    logic signed [SW-1:0]          s_s;
    logic [QM:0]                   clamp_s;
    logic [QM:0]                   e_s;
    logic [2*QM:0]                 sq_s;
    logic [QM:0]                   term_s;
    logic                          tgt_s;
    logic                          mispredict_s;
    logic [BITWIDTH-1:0]           costSat_s;

    // State register; clearAcc forces IDLE ahead of any transition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else if (clearAcc) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic: one channel per CALC cycle, DONE only on the last sample.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (newOutput) begin
                    nextState_s = CALC;
                end else begin
                    nextState_s = IDLE;
                end
            end
            CALC: begin
                if (ch_r == LAST_CH) begin
                    if (sampleCnt_r == LAST_SAMPLE) begin
                        nextState_s = DONE;
                    end else begin
                        nextState_s = IDLE;
                    end
                end else begin
                    nextState_s = CALC;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Output decode: busy is registered from the state being entered.
    always_comb begin
        busyNext_s = 1'b0;
        if (clearAcc) begin
            busyNext_s = 1'b0;
        end else begin
            case (nextState_s)
                CALC:    busyNext_s = 1'b1;
                DONE:    busyNext_s = 1'b1;
                default: busyNext_s = 1'b0;
            endcase
        end
    end

    // Per-channel hard sigmoid, error term and sign-based prediction check.
    always_comb begin
        x_s          = capWord_r[ch_r*BITWIDTH +: BITWIDTH];
        tgt_s        = capTarget_r[ch_r];
        xExt_s       = {x_s[BITWIDTH-1], x_s};
        s_s          = (xExt_s >>> 2) + HALF_S;
        clamp_s      = {(QM + 1){1'b0}};
        if (s_s < ZERO_S) begin
            clamp_s = {(QM + 1){1'b0}};
        end else if (s_s > ONE_S) begin
            clamp_s = ONE_E;
        end else begin
            clamp_s = s_s[QM:0];
        end
        if (tgt_s) begin
            e_s = ONE_E - clamp_s;
        end else begin
            e_s = clamp_s;
        end
        sq_s = {{QM{1'b0}}, e_s} * {{QM{1'b0}}, e_s};
        if (MODE == 0) begin
            term_s = (QM + 1)'(sq_s >> QM);
        end else begin
            term_s = e_s;
        end
        mispredict_s = (~x_s[BITWIDTH-1]) != tgt_s;
    end

    // Cost saturation into the signed output range.
    always_comb begin
        if (acc_r > COST_MAX) begin
            costSat_s = COST_MAX[BITWIDTH-1:0];
        end else begin
            costSat_s = acc_r[BITWIDTH-1:0];
        end
    end

    // Datapath: capture, accumulation, cost publication and monitoring counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capWord_r     <= {(OUTPUT_SZ * BITWIDTH){1'b0}};
            capTarget_r   <= {OUTPUT_SZ{1'b0}};
            ch_r          <= {CH_W{1'b0}};
            sampleCnt_r   <= {SC_W{1'b0}};
            acc_r         <= {ACC_W{1'b0}};
            busy_r        <= 1'b0;
            costFunc_r    <= {BITWIDTH{1'b0}};
            newCostFunc_r <= 1'b0;
            wrongBits_r   <= {CNT_W{1'b0}};
            overrun_r     <= 1'b0;
        end else if (clearAcc) begin
            ch_r          <= {CH_W{1'b0}};
            sampleCnt_r   <= {SC_W{1'b0}};
            acc_r         <= {ACC_W{1'b0}};
            busy_r        <= 1'b0;
            newCostFunc_r <= 1'b0;
            wrongBits_r   <= {CNT_W{1'b0}};
            overrun_r     <= 1'b0;
        end else begin
            busy_r        <= busyNext_s;
            newCostFunc_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (newOutput) begin
                        capWord_r   <= networkOutput;
                        capTarget_r <= target;
                        ch_r        <= {CH_W{1'b0}};
                    end
                end
                CALC: begin
                    acc_r <= acc_r + {{(ACC_W - QM - 1){1'b0}}, term_s};
                    if (mispredict_s && (wrongBits_r != CNT_MAX)) begin
                        wrongBits_r <= wrongBits_r + CNT_W'(1'b1);
                    end
                    if (ch_r == LAST_CH) begin
                        ch_r <= {CH_W{1'b0}};
                        // DONE clears the counter when the sequence completes.
                        if (sampleCnt_r != LAST_SAMPLE) begin
                            sampleCnt_r <= sampleCnt_r + SC_W'(1'b1);
                        end
                    end else begin
                        ch_r <= ch_r + CH_W'(1'b1);
                    end
                    if (newOutput) begin
                        overrun_r <= 1'b1;
                    end
                end
                DONE: begin
                    costFunc_r    <= costSat_s;
                    newCostFunc_r <= 1'b1;
                    acc_r         <= {ACC_W{1'b0}};
                    sampleCnt_r   <= {SC_W{1'b0}};
                    if (newOutput) begin
                        overrun_r <= 1'b1;
                    end
                end
                default: begin
                    ch_r <= {CH_W{1'b0}};
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign costFunc    = costFunc_r;
    assign newCostFunc = newCostFunc_r;
    assign wrongBits   = wrongBits_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_cost_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cost_accumulator
//   Drives two accumulator instances, both on one clock:
//     A: OUTPUT_SZ=4, SEQ_LEN=16, squared error
//     B: OUTPUT_SZ=1, SEQ_LEN=2,  absolute error
//   The reference model works directly from the arithmetic rules: floor
//   division, clamp, error, and a per-sequence sum capped at 2^17-1.
// -----------------------------------------------------------------------------
module tb_cost_accumulator;

    localparam int BW      = 18;
    localparam int HALF    = 1024;     // 2^(QM-1)
    localparam int ONE     = 2048;     // 2^QM
    localparam int MAXCOST = 131071;   // 2^(BW-1)-1

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clrA = 1'b0, nOA = 1'b0, clrB = 1'b0, nOB = 1'b0;
    logic [71:0] outA = 72'd0;
    logic [3:0]  tgtA = 4'd0;
    logic [17:0] outB = 18'd0;
    logic        tgtB = 1'b0;
    logic        busyA, ncA, ovA, busyB, ncB, ovB;
    logic [17:0] costA, costB;
    logic [15:0] wbA, wbB;

    int nPass  = 0;
    int nTotal = 0;

    int OSZ[2]   = '{4, 1};
    int SEQ[2]   = '{16, 2};
    int MODEP[2] = '{0, 1};
    int mAcc[2], mCnt[2], mCost[2], mWrong[2];
    bit mOvr[2];

    cost_accumulator #(.OUTPUT_SZ(4), .SEQ_LEN(16), .MODE(0)) dutA (
        .clock(clock), .reset(reset), .clearAcc(clrA), .newOutput(nOA),
        .networkOutput(outA), .target(tgtA), .busy(busyA), .costFunc(costA),
        .newCostFunc(ncA), .wrongBits(wbA), .overrun(ovA)
    );

    cost_accumulator #(.OUTPUT_SZ(1), .SEQ_LEN(2), .MODE(1)) dutB (
        .clock(clock), .reset(reset), .clearAcc(clrB), .newOutput(nOB),
        .networkOutput(outB), .target(tgtB), .busy(busyB), .costFunc(costB),
        .newCostFunc(ncB), .wrongBits(wbB), .overrun(ovB)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Error term for one element, computed with plain integer arithmetic.
    function automatic int termOf(input int xi, input bit t, input int mode);
        int q, s, e;
        q = (xi >= 0) ? xi / 4 : -((-xi + 3) / 4);
        s = HALF + q;
        if (s < 0) s = 0;
        if (s > ONE) s = ONE;
        e = t ? (ONE - s) : s;
        return (mode == 1) ? e : (e * e) / ONE;
    endfunction

    function automatic logic [71:0] randWord();
        logic [71:0] w;
        logic [17:0] x;
        for (int c = 0; c < 4; c++) begin
            if ($urandom_range(1, 0) == 1) x = 18'($urandom);
            else x = 18'(int'($urandom_range(12000, 0)) - 6000);
            w[c*18 +: 18] = x;
        end
        return w;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mAcc[k] = 0; mCnt[k] = 0; mCost[k] = 0; mWrong[k] = 0; mOvr[k] = 1'b0;
        end
    endtask

    task automatic checkAll(input int which, input string nm);
        if (which == 0) begin
            check({nm, ".A.busy"}, busyA, 0);
            check({nm, ".A.newCost"}, ncA, 0);
            check({nm, ".A.cost"}, costA, mCost[0]);
            check({nm, ".A.wrong"}, wbA, mWrong[0]);
            check({nm, ".A.overrun"}, ovA, mOvr[0]);
        end else begin
            check({nm, ".B.busy"}, busyB, 0);
            check({nm, ".B.newCost"}, ncB, 0);
            check({nm, ".B.cost"}, costB, mCost[1]);
            check({nm, ".B.wrong"}, wbB, mWrong[1]);
            check({nm, ".B.overrun"}, ovB, mOvr[1]);
        end
    endtask

    // One full sample: strobe, model update, then cycle-by-cycle busy/strobe checks.
    // dup re-strobes newOutput one cycle later to provoke an overrun.
    task automatic runSample(input int which, input logic [71:0] w, input logic [3:0] t, input bit dup);
        int os, xi;
        bit comp;
        logic signed [17:0] xs;
        logic b, nc;
        string nm;
        nm = (which == 0) ? "A" : "B";
        os = OSZ[which];
        if (which == 0) begin nOA = 1'b1; outA = w; tgtA = t; end
        else begin nOB = 1'b1; outB = w[17:0]; tgtB = t[0]; end
        for (int c = 0; c < os; c++) begin
            xs = w[c*18 +: 18];
            xi = xs;
            mAcc[which] += termOf(xi, t[c], MODEP[which]);
            if ((xi >= 0) != t[c] && mWrong[which] < 65535) mWrong[which]++;
        end
        comp = (mCnt[which] == SEQ[which] - 1);
        if (comp) begin
            mCost[which] = (mAcc[which] > MAXCOST) ? MAXCOST : mAcc[which];
            mAcc[which] = 0;
            mCnt[which] = 0;
        end else begin
            mCnt[which]++;
        end
        if (dup) mOvr[which] = 1'b1;
        for (int i = 0; i <= os; i++) begin
            @(negedge clock);
            if (which == 0) begin
                nOA = dup && (i == 0);
                outA = {8'($urandom), $urandom, $urandom};
                tgtA = 4'($urandom);
                b = busyA; nc = ncA;
            end else begin
                nOB = dup && (i == 0);
                outB = 18'($urandom);
                tgtB = 1'($urandom);
                b = busyB; nc = ncB;
            end
            check($sformatf("%s.busy[%0d]", nm, i), b, (i < os) ? 1 : comp);
            check($sformatf("%s.newCost[%0d]", nm, i), nc, 0);
        end
        @(negedge clock);
        if (which == 0) begin
            check("A.newCost.end", ncA, comp);
            check("A.busy.end", busyA, 0);
            check("A.cost", costA, mCost[0]);
            check("A.wrong", wbA, mWrong[0]);
            check("A.overrun", ovA, mOvr[0]);
        end else begin
            check("B.newCost.end", ncB, comp);
            check("B.busy.end", busyB, 0);
            check("B.cost", costB, mCost[1]);
            check("B.wrong", wbB, mWrong[1]);
            check("B.overrun", ovB, mOvr[1]);
        end
    endtask

    initial begin
        logic [71:0] satW;
        for (int c = 0; c < 4; c++) satW[c*18 +: 18] = -18'sd8192;
        modelReset();

        // Reset state
        repeat (2) @(negedge clock);
        checkAll(0, "reset");
        checkAll(1, "reset");
        reset = 1'b1;
        @(negedge clock);

        // Saturation: 64 elements of x=-8192, target=1 -> 64*2048 capped
        for (int s = 0; s < 16; s++) runSample(0, satW, 4'hF, 1'b0);
        check("A.satCost", costA, MAXCOST);
        check("A.satWrong", wbA, 64);

        // Random sequences on A, with one overrun in the middle
        for (int s = 0; s < 32; s++) runSample(0, randWord(), 4'($urandom), s == 20);

        // Partial sequence, then clearAcc coincident with newOutput
        for (int s = 0; s < 5; s++) runSample(0, randWord(), 4'($urandom), 1'b0);
        clrA = 1'b1; nOA = 1'b1; outA = randWord(); tgtA = 4'($urandom);
        @(negedge clock);
        clrA = 1'b0; nOA = 1'b0;
        mAcc[0] = 0; mCnt[0] = 0; mWrong[0] = 0; mOvr[0] = 1'b0;
        checkAll(0, "clear");
        @(negedge clock);
        check("clear.noCapture", busyA, 0);
        for (int s = 0; s < 16; s++) runSample(0, randWord(), 4'($urandom), 1'b0);

        // Absolute error on B: x=0,target=1 and x=0,target=0 both give 1024 per sample
        runSample(1, 72'd0, 4'h1, 1'b0);
        runSample(1, 72'd0, 4'h1, 1'b0);
        check("B.absCost1", costB, 2048);
        runSample(1, 72'd0, 4'h0, 1'b0);
        runSample(1, 72'd0, 4'h0, 1'b0);
        check("B.absCost0", costB, 2048);
        check("B.absWrong", wbB, 2);
        for (int s = 0; s < 20; s++) runSample(1, randWord(), 4'($urandom), s == 7);

        // Asynchronous reset during the second CALC cycle of a mid-sequence sample
        for (int s = 0; s < 3; s++) runSample(0, randWord(), 4'($urandom), 1'b0);
        nOA = 1'b1; outA = randWord(); tgtA = 4'($urandom);
        @(negedge clock);
        nOA = 1'b0;
        @(negedge clock);
        check("midCalc.busy", busyA, 1);
        reset = 1'b0;
        #1;
        modelReset();
        checkAll(0, "asyncReset");
        checkAll(1, "asyncReset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int s = 0; s < 16; s++) runSample(0, randWord(), 4'($urandom), 1'b0);
        for (int s = 0; s < 2; s++) runSample(1, randWord(), 4'($urandom), 1'b0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
